vp_fb_sched: RTL and testbench
==============================

# vp_fb_sched

Value-prediction feedback scheduler. It collects up to two retire-time feedback packets per cycle from the i0 and i1 pipes and buffers them in a small FIFO. It drains one table update per cycle through a ready/valid port into the single-write-port value-prediction table, computing the new confidence on the way. It also owns table initialization: it sweeps every entry after reset and on `vp_clear`. It sits between the decode/commit feedback path (`vp_fb_pkt_t` producers) and the VP table.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `INDEX_BITS`, 6: table index width; index = `pc[INDEX_BITS:1]`.
- `CONF_W`, 2: confidence width; equals `P_CONF_WIDTH`.
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-high.
- `vp_clear` in 1: request table re-initialization.
- `i0_fb_valid`, `i1_fb_valid` in 1: feedback valid per pipe.
- `i0_fb_misp`, `i1_fb_misp` in 1: the prediction was wrong.
- `i0_fb_pc`, `i1_fb_pc` in 31: pc[31:1].
- `i0_fb_actual`, `i1_fb_actual` in 32: actual result.
- `i0_fb_conf`, `i1_fb_conf` in CONF_W: confidence used at prediction.
- `fb_full` out 1: fewer than 2 free FIFO slots.
- `upd_valid` out 1: table write request.
- `upd_ready` in 1: table accepts the write.
- `upd_init` out 1: the write is an init write.
- `upd_index` out INDEX_BITS: table index.
- `upd_value` out 32: value to store.
- `upd_conf` out CONF_W: new confidence.
- `init_busy` out 1: FSM is in INIT.
- `drop_cnt` out 16: saturating count of dropped feedback.

## Operation
- **FSM states:** INIT and RUN. Reset enters INIT with `init_ptr` = 0.
- **INIT:**
  - Drives `upd_valid`=1, `upd_init`=1, `upd_index`=`init_ptr`, `upd_value`=0, `upd_conf`=0.
  - `init_ptr` increments on each `upd_valid & upd_ready`.
  - The handshake at `init_ptr`=2^INDEX_BITS−1 moves the FSM to RUN.
  - Feedback arriving in INIT is ignored and not counted as dropped.
- **RUN:**
  - `upd_valid` = (count≠0).
  - `upd_init`=0.
  - Index, value and conf come from the FIFO head.
  - The head pops on `upd_valid & upd_ready`.
- **Confidence on dequeue:**
  - misp → 0.
  - Correct → min(conf+1, 2^CONF_W−1).
  - `upd_value` is always the actual result.
- **Enqueue:**
  - free = DEPTH − count, taken from the pre-cycle value. A same-cycle pop does not free space for a same-cycle push.
  - Valid packets are accepted in order i0 then i1, up to free.
  - If i0 is invalid, i1 goes in the first free slot.
  - Packets that do not fit are dropped; `drop_cnt` += number dropped, saturating at 0xFFFF.
- **Count update:** count' = count + pushes − pop. Pointers wrap modulo DEPTH.
- **`vp_clear`:**
  - In RUN: the FIFO is emptied (pointers and count to 0), pending entries are discarded and not counted as drops, and the FSM goes to INIT with `init_ptr`=0.
  - In INIT: `init_ptr` restarts at 0.
  - `vp_clear` overrides a same-cycle handshake and same-cycle feedback.
- **`drop_cnt`:** cleared only by `rst`.

## Timing
- **Reset values:**
  - State INIT, `init_ptr`=0, count=0, `drop_cnt`=0.
  - Outputs: `upd_valid`=1, `upd_init`=1, `upd_index`=0, `upd_value`=0, `upd_conf`=0, `init_busy`=1, `fb_full`=0.
  - The table ignores writes while its own reset is asserted.
- **Init sweep:** 2^INDEX_BITS cycles with `upd_ready` held high.
- **Latency:** feedback registered at edge N appears at `upd_valid` in cycle N+1 when the FIFO was empty.
- **Throughput:** 1 update per cycle sustained.
- **`fb_full`:** decoded from registered count only, with no combinational path from inputs.
- **Handshake:** while `upd_valid`=1 and `upd_ready`=0, all `upd_*` outputs hold stable.
- **`vp_clear`:** takes effect at the next edge.

## Configuration
- `RV_VP_FB_FILTER_EN` defined:
  - At enqueue, a packet with misp=0 and conf=2^CONF_W−1 is discarded. It needs no table change.
  - Discarded packets are not counted as drops and consume no slot.
- `RV_VP_FB_FILTER_EN` undefined: every valid packet is enqueued.

## Test plan
- **Reset then sweep:** `upd_ready`=1 → 64 init writes, indices 0..63, with `init_busy` falling after index 63. Then `upd_ready` toggled 1/0 during a second sweep → each index is held stable until accepted.
- **Confidence arithmetic:**
  - i0 pc=0x80 (index 0), conf=1, misp=0, actual=0x1234 → next cycle `upd_index`=0, `upd_conf`=2, `upd_value`=0x1234.
  - misp=1, conf=3 → `upd_conf`=0.
- **Dual push with stall:** `upd_ready`=0 and two dual-valid cycles → count=4, `fb_full`=1. A third dual-valid cycle → `drop_cnt`=2. Drain order is i0, i1, i0, i1.
- **Partial fit:** count=3, i0 and i1 valid, same-cycle pop → only i0 accepted, `drop_cnt`+1, count stays 3.
- **`vp_clear` in RUN:** issued with 3 entries queued → FIFO empties, `drop_cnt` unchanged, sweep restarts at index 0. Feedback during INIT is ignored.
- **Filter:** misp=0, conf=3 with `RV_VP_FB_FILTER_EN` defined → no `upd_valid`. With the macro undefined → update issued with `upd_conf`=3.

Source files
------------

// File: rtl/vp_fb_sched.sv
// rtl/vp_fb_sched.sv - value-prediction feedback scheduler with table init sweep
//
// Collects up to two retire feedback packets per cycle (i0, i1) into a DEPTH-entry
// FIFO and drains one VP-table write per cycle over a valid/ready port, computing
// the new confidence at dequeue. After reset and on vp_clear it sweeps every table
// entry with zero writes before accepting feedback again.
//
// Ports:
//   clk, rst (async, active-high), vp_clear        - clock, reset, re-init request
//   i0_fb_* / i1_fb_* (valid, misp, pc[31:1],
//                      actual, conf)               - feedback packets per pipe
//   fb_full                                        - fewer than 2 free FIFO slots
//   upd_valid / upd_ready                          - table write handshake
//   upd_init, upd_index, upd_value, upd_conf       - table write payload
//   init_busy                                      - init sweep in progress
//   drop_cnt                                       - saturating dropped-feedback count
//
// Configuration macro: RV_VP_FB_FILTER_EN - when defined, correct predictions that
// already hold maximum confidence are discarded at enqueue (no table change needed).
module vp_fb_sched #(
    parameter int DEPTH      = 4,
    parameter int INDEX_BITS = 6,
    parameter int CONF_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vp_clear,
    input  logic                  i0_fb_valid,
    input  logic                  i0_fb_misp,
    input  logic [30:0]           i0_fb_pc,
    input  logic [31:0]           i0_fb_actual,
    input  logic [CONF_W-1:0]     i0_fb_conf,
    input  logic                  i1_fb_valid,
    input  logic                  i1_fb_misp,
    input  logic [30:0]           i1_fb_pc,
    input  logic [31:0]           i1_fb_actual,
    input  logic [CONF_W-1:0]     i1_fb_conf,
    output logic                  fb_full,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic                  upd_init,
    output logic [INDEX_BITS-1:0] upd_index,
    output logic [31:0]           upd_value,
    output logic [CONF_W-1:0]     upd_conf,
    output logic                  init_busy,
    output logic [15:0]           drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CONF_W-1:0]     CONF_MAX = {CONF_W{1'b1}};
    localparam logic [INDEX_BITS-1:0] IDX_LAST = {INDEX_BITS{1'b1}};
    localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]         FULL_AT  = CW'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                state;
    logic [INDEX_BITS-1:0] init_ptr;
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count;

    logic [INDEX_BITS-1:0] idx_mem  [DEPTH];
    logic [31:0]           val_mem  [DEPTH];
    logic [CONF_W-1:0]     conf_mem [DEPTH];
    logic                  misp_mem [DEPTH];

    // Only the table-index bits of the pc are meaningful here.
    logic unused_pc;
    assign unused_pc = ^{i0_fb_pc[30:INDEX_BITS], i1_fb_pc[30:INDEX_BITS]};

    logic filt0, filt1;
`ifdef RV_VP_FB_FILTER_EN
    assign filt0 = ~i0_fb_misp & (i0_fb_conf == CONF_MAX);
    assign filt1 = ~i1_fb_misp & (i1_fb_conf == CONF_MAX);
`else
    assign filt0 = 1'b0;
    assign filt1 = 1'b0;
`endif

    logic          v0, v1, acc0, acc1, run_go, pop;
    logic [CW-1:0] free, push_n;
    logic [1:0]    drop_n;
    logic [PW-1:0] wptr1;
    logic [16:0]   drop_sum;

    assign v0 = i0_fb_valid & ~filt0;
    assign v1 = i1_fb_valid & ~filt1;

    // Free space comes from the registered count: a same-cycle pop does not help.
    assign free   = DEPTH_C - count;
    assign acc0   = v0 & (free != '0);
    assign acc1   = v1 & (free > CW'(acc0));
    assign push_n = CW'(acc0) + CW'(acc1);
    assign drop_n = 2'(v0 & ~acc0) + 2'(v1 & ~acc1);

    // i1 lands right behind i0, or in the first free slot when i0 is not pushed.
    assign wptr1 = wptr + PW'(acc0);

    assign run_go   = (state == S_RUN) & ~vp_clear;
    assign pop      = (state == S_RUN) & (count != '0) & upd_ready;
    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_n);

    logic [CONF_W-1:0] head_conf, next_conf;
    assign head_conf = conf_mem[rptr];
    assign next_conf = misp_mem[rptr]          ? '0 :
                       (head_conf == CONF_MAX) ? CONF_MAX : head_conf + 1'b1;

    // Payload is a pure function of registered state, so it holds during a stall.
    assign init_busy = (state == S_INIT);
    assign upd_valid = init_busy | (count != '0);
    assign upd_init  = init_busy;
    assign upd_index = init_busy ? init_ptr : idx_mem[rptr];
    assign upd_value = init_busy ? 32'd0    : val_mem[rptr];
    assign upd_conf  = init_busy ? '0       : next_conf;
    assign fb_full   = (count >= FULL_AT);

    always_ff @(posedge clk) begin
        if (run_go && acc0) begin
            idx_mem[wptr]  <= i0_fb_pc[INDEX_BITS-1:0];
            val_mem[wptr]  <= i0_fb_actual;
            conf_mem[wptr] <= i0_fb_conf;
            misp_mem[wptr] <= i0_fb_misp;
        end
        if (run_go && acc1) begin
            idx_mem[wptr1]  <= i1_fb_pc[INDEX_BITS-1:0];
            val_mem[wptr1]  <= i1_fb_actual;
            conf_mem[wptr1] <= i1_fb_conf;
            misp_mem[wptr1] <= i1_fb_misp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_INIT;
            init_ptr <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (vp_clear) begin
                        init_ptr <= '0;
                    end else if (upd_ready) begin
                        if (init_ptr == IDX_LAST) begin
                            state    <= S_RUN;
                            init_ptr <= '0;
                        end else begin
                            init_ptr <= init_ptr + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (vp_clear) begin
                        // Pending feedback is discarded silently, not counted as drops.
                        state    <= S_INIT;
                        init_ptr <= '0;
                        wptr     <= '0;
                        rptr     <= '0;
                        count    <= '0;
                    end else begin
                        wptr     <= wptr + PW'(push_n);
                        rptr     <= rptr + PW'(pop);
                        count    <= count + push_n - CW'(pop);
                        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_vp_fb_sched.sv
// tb/tb_vp_fb_sched.sv - randomized scoreboard bench for vp_fb_sched
module tb_vp_fb_sched;
    localparam int DEPTH = 4;
    localparam int NENT  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vp_clear = 1'b0;
    logic        i0_fb_valid = 1'b0, i0_fb_misp = 1'b0;
    logic [30:0] i0_fb_pc = '0;
    logic [31:0] i0_fb_actual = '0;
    logic [1:0]  i0_fb_conf = '0;
    logic        i1_fb_valid = 1'b0, i1_fb_misp = 1'b0;
    logic [30:0] i1_fb_pc = '0;
    logic [31:0] i1_fb_actual = '0;
    logic [1:0]  i1_fb_conf = '0;
    logic        upd_ready = 1'b1;
    logic        fb_full, upd_valid, upd_init, init_busy;
    logic [5:0]  upd_index;
    logic [31:0] upd_value;
    logic [1:0]  upd_conf;
    logic [15:0] drop_cnt;

    vp_fb_sched dut (
        .clk(clk), .rst(rst), .vp_clear(vp_clear),
        .i0_fb_valid(i0_fb_valid), .i0_fb_misp(i0_fb_misp), .i0_fb_pc(i0_fb_pc),
        .i0_fb_actual(i0_fb_actual), .i0_fb_conf(i0_fb_conf),
        .i1_fb_valid(i1_fb_valid), .i1_fb_misp(i1_fb_misp), .i1_fb_pc(i1_fb_pc),
        .i1_fb_actual(i1_fb_actual), .i1_fb_conf(i1_fb_conf),
        .fb_full(fb_full), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_init(upd_init), .upd_index(upd_index), .upd_value(upd_value),
        .upd_conf(upd_conf), .init_busy(init_busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] val;
        logic [1:0]  conf;
    } upd_t;

    upd_t exp_q[$];
    upd_t m_arr[$];
    bit   m_init = 1'b1;
    int   m_ptr = 0;
    int   m_drop = 0;
    int   m_free;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit keep(input bit v, input bit misp, input logic [1:0] conf);
        if (!v) return 1'b0;
`ifdef RV_VP_FB_FILTER_EN
        if (!misp && conf == 2'd3) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic upd_t mk(input logic [30:0] pc, input logic [31:0] act,
                                input bit misp, input logic [1:0] conf);
        upd_t u;
        u.idx  = pc[5:0];
        u.val  = act;
        u.conf = misp ? 2'd0 : (conf == 2'd3 ? 2'd3 : conf + 2'd1);
        return u;
    endfunction

    // Reference model: a queue of pending table writes plus an init sweep pointer.
    always @(posedge clk) begin
        if (rst) begin
            m_init = 1'b1; m_ptr = 0; m_drop = 0; exp_q.delete();
        end else if (m_init) begin
            if (vp_clear) m_ptr = 0;
            else if (upd_ready) begin
                if (m_ptr == NENT - 1) begin m_init = 1'b0; m_ptr = 0; end
                else m_ptr++;
            end
        end else if (vp_clear) begin
            exp_q.delete(); m_init = 1'b1; m_ptr = 0;
        end else begin
            m_free = DEPTH - exp_q.size();
            m_arr.delete();
            if (keep(i0_fb_valid, i0_fb_misp, i0_fb_conf))
                m_arr.push_back(mk(i0_fb_pc, i0_fb_actual, i0_fb_misp, i0_fb_conf));
            if (keep(i1_fb_valid, i1_fb_misp, i1_fb_conf))
                m_arr.push_back(mk(i1_fb_pc, i1_fb_actual, i1_fb_misp, i1_fb_conf));
            if (exp_q.size() > 0 && upd_ready) void'(exp_q.pop_front());
            foreach (m_arr[k]) begin
                if (m_free > 0) begin exp_q.push_back(m_arr[k]); m_free--; end
                else if (m_drop < 65535) m_drop++;
            end
        end
    end

    // Monitor: compares the presented write against the model every cycle.
    always @(negedge clk) begin
        if (!done) begin
            if (m_init) begin
                chk("init_valid", upd_valid, 1);
                chk("init_flag", upd_init, 1);
                chk("init_index", upd_index, m_ptr);
                chk("init_value", upd_value, 0);
                chk("init_conf", upd_conf, 0);
                chk("init_busy", init_busy, 1);
            end else begin
                chk("run_valid", upd_valid, exp_q.size() != 0);
                chk("run_flag", upd_init, 0);
                chk("run_busy", init_busy, 0);
                if (exp_q.size() != 0) begin
                    chk("upd_index", upd_index, exp_q[0].idx);
                    chk("upd_value", upd_value, exp_q[0].val);
                    chk("upd_conf", upd_conf, exp_q[0].conf);
                end
            end
            chk("fb_full", fb_full, exp_q.size() > DEPTH - 2);
            chk("drop_cnt", drop_cnt, m_drop);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input bit v, input bit m, input logic [30:0] pc,
                        input logic [31:0] a, input logic [1:0] c);
        i0_fb_valid = v; i0_fb_misp = m; i0_fb_pc = pc; i0_fb_actual = a; i0_fb_conf = c;
    endtask

    task automatic set1(input bit v, input bit m, input logic [30:0] pc,
                        input logic [31:0] a, input logic [1:0] c);
        i1_fb_valid = v; i1_fb_misp = m; i1_fb_pc = pc; i1_fb_actual = a; i1_fb_conf = c;
    endtask

    task automatic idle();
        set0(0, 0, '0, '0, '0);
        set1(0, 0, '0, '0, '0);
    endtask

    task automatic rnd_fb();
        set0($urandom_range(0, 1), $urandom_range(0, 1), 31'($urandom), $urandom, 2'($urandom));
        set1($urandom_range(0, 1), $urandom_range(0, 1), 31'($urandom), $urandom, 2'($urandom));
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        repeat (70) step();                      // full init sweep with ready high

        vp_clear = 1'b1; step(); vp_clear = 1'b0;
        for (int i = 0; i < 140; i++) begin      // second sweep with ready toggling
            upd_ready = i[0];
            step();
        end
        upd_ready = 1'b1;
        repeat (4) step();

        set0(1, 0, 31'h40, 32'h1234, 2'd1); step();  // conf 1 correct -> 2
        set0(1, 1, 31'h55, 32'hDEAD, 2'd3); step();  // mispredict -> 0
        idle(); repeat (3) step();

        upd_ready = 1'b0;                        // dual push under stall, then overflow
        set0(1, 0, 31'h01, 32'h11, 2'd0); set1(1, 1, 31'h02, 32'h22, 2'd2); step();
        set0(1, 0, 31'h03, 32'h33, 2'd1); set1(1, 0, 31'h04, 32'h44, 2'd2); step();
        set0(1, 0, 31'h05, 32'h55, 2'd0); set1(1, 0, 31'h06, 32'h66, 2'd0); step();
        idle(); upd_ready = 1'b1; repeat (6) step();

        upd_ready = 1'b0;                        // partial fit with same-cycle pop
        set0(1, 0, 31'h07, 32'h77, 2'd0); set1(1, 0, 31'h08, 32'h88, 2'd1); step();
        set0(1, 1, 31'h09, 32'h99, 2'd2); idle(); set0(1, 1, 31'h09, 32'h99, 2'd2); step();
        upd_ready = 1'b1;
        set0(1, 0, 31'h0A, 32'hAA, 2'd1); set1(1, 0, 31'h0B, 32'hBB, 2'd1); step();
        idle(); repeat (6) step();

        upd_ready = 1'b0;                        // clear with three entries queued
        set0(1, 0, 31'h0C, 32'hCC, 2'd0); set1(1, 0, 31'h0D, 32'hDD, 2'd0); step();
        set0(1, 0, 31'h0E, 32'hEE, 2'd0); set1(0, 0, '0, '0, '0); step();
        idle(); vp_clear = 1'b1; step(); vp_clear = 1'b0;
        upd_ready = 1'b1;
        for (int i = 0; i < 70; i++) begin       // feedback during INIT is ignored
            rnd_fb();
            step();
        end
        idle(); repeat (2) step();

        set0(1, 0, 31'h0F, 32'hF0F0, 2'd3); step();  // saturated-confidence packet
        idle(); repeat (3) step();

        for (int i = 0; i < 3000; i++) begin
            upd_ready = ($urandom_range(0, 3) != 0);
            vp_clear  = ($urandom_range(0, 399) == 0);
            rnd_fb();
            step();
        end
        idle(); vp_clear = 1'b0; upd_ready = 1'b1;
        repeat (4) step();

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
